// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with DEPTH = 2**ADDR_W entries.
// It has RD_PORTS registered read ports, two write ports and a busy
// scoreboard bit per register. Decode reserves a destination register,
// which marks it busy. A writeback to that register releases it.
//
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data
// and ready status to the read ports. When it is undefined, reads return
// the stored pre-write value and the pre-edge busy status.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rd_addr         packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data         registered read data, port p at [p*DATA_W +: DATA_W]
//   rd_ready        registered per-port flag: 1 = register not busy
//   w_enable1/addr1/d1writeback   write port 1
//   w_enable2/addr2/d2writeback   write port 2 (wins on address collision)
//   rsv_en/rsv_addr reservation request
//   rsv_ok          combinational grant for the current reservation
//   busy_cnt        registered count of busy registers (0..DEPTH)
module reg_file_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_ready,
  input  logic                         w_enable1,
  input  logic [ADDR_W-1:0]            addr1,
  input  logic [DATA_W-1:0]            d1writeback,
  input  logic                         w_enable2,
  input  logic [ADDR_W-1:0]            addr2,
  input  logic [DATA_W-1:0]            d2writeback,
  input  logic                         rsv_en,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic                         rsv_ok,
  output logic [ADDR_W:0]              busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [CNT_W-1:0]  r_busy_cnt;

  logic              w_rel_rsv;
  logic              w_rsv_ok;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Reservation grant: the register is free, or it is released in this cycle.
  always_comb begin
    w_rel_rsv = (w_enable1 && (addr1 == rsv_addr)) ||
                (w_enable2 && (addr2 == rsv_addr));
    w_rsv_ok  = rsv_en && (!r_busy[rsv_addr] || w_rel_rsv);
  end

  assign rsv_ok = w_rsv_ok;

  // Next busy vector: releases first, then the grant, so reserve-on-release ends busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_enable1) w_busy_nxt[addr1] = 1'b0;
    if (w_enable2) w_busy_nxt[addr2] = 1'b0;
    if (w_rsv_ok)  w_busy_nxt[rsv_addr] = 1'b1;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
    end
  end

  // Storage array. Port 2 is assigned last, so its data wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_enable1) r_regs[addr1] <= d1writeback;
      if (w_enable2) r_regs[addr2] <= d2writeback;
    end
  end

  // Scoreboard bits and their population count, updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  // Independent read ports, each with one cycle of latency.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_d;
    logic              w_rdy;
    logic [DATA_W-1:0] r_d;
    logic              r_rdy;

    assign w_ra = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      w_d   = r_regs[w_ra];
      w_rdy = !r_busy[w_ra];
`ifdef RF_BYPASS_EN
      // Forward the same-cycle write. Port 2 has priority, the same as for the array.
      if (w_enable2 && (addr2 == w_ra)) begin
        w_d   = d2writeback;
        w_rdy = !(w_rsv_ok && (rsv_addr == w_ra));
      end else if (w_enable1 && (addr1 == w_ra)) begin
        w_d   = d1writeback;
        w_rdy = !(w_rsv_ok && (rsv_addr == w_ra));
      end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_d   <= '0;
        r_rdy <= 1'b0;
      end else begin
        r_d   <= w_d;
        r_rdy <= w_rdy;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = r_d;
    assign rd_ready[p]                 = r_rdy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb in its default configuration
// (DATA_W=16, ADDR_W=4, RD_PORTS=2). Expected values are hand-computed.
// Define RF_BYPASS_EN here as well to match a forwarding build.
module tb_reg_file_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_ready;
  logic        w_enable1;
  logic [3:0]  addr1;
  logic [15:0] d1writeback;
  logic        w_enable2;
  logic [3:0]  addr2;
  logic [15:0] d2writeback;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        rsv_ok;
  logic [4:0]  busy_cnt;

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(2)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .w_enable1(w_enable1), .addr1(addr1),
    .d1writeback(d1writeback), .w_enable2(w_enable2), .addr2(addr2),
    .d2writeback(d2writeback), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  rdy;
    logic [4:0]  cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;
  logic rd_issue;
  logic rd_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Mark the read issued in this cycle and queue what it must return.
  task automatic expect_rd(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [1:0] rdy, input logic [4:0] cnt);
    exp_t x;
    rd_addr  = {a1, a0};
    rd_issue = 1'b1;
    x.tag = tag; x.d0 = d0; x.d1 = d1; x.rdy = rdy; x.cnt = cnt;
    q.push_back(x);
  endtask

  task automatic idle();
    w_enable1 = 1'b0; addr1 = '0; d1writeback = '0;
    w_enable2 = 1'b0; addr2 = '0; d2writeback = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    rd_issue = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic reserve(input logic [3:0] a, input logic exp_ok, input string name);
    rsv_en = 1'b1; rsv_addr = a;
    #1;
    chk(name, 32'(rsv_ok), 32'(exp_ok));
  endtask

  // Read results become visible one edge after issue.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= rd_issue;
  end

  // Monitor: compare each presented read result against the head of the queue.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: read result with empty queue, got %0h", rd_data);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_d0"}, 32'(rd_data[15:0]), 32'(e.d0));
        chk({e.tag, "_d1"}, 32'(rd_data[31:16]), 32'(e.d1));
        chk({e.tag, "_rdy"}, 32'(rd_ready), 32'(e.rdy));
        chk({e.tag, "_cnt"}, 32'(busy_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    #12;
    chk("reset_cnt", 32'(busy_cnt), 0);
    chk("reset_rdy", 32'(rd_ready), 0);
    chk("reset_data", rd_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    expect_rd("rd_after_reset", 4'd3, 4'd12, 16'h0000, 16'h0000, 2'b11, 5'd0);
    step();

    w_enable1 = 1'b1; addr1 = 4'hA; d1writeback = 16'h1A1A;
    w_enable2 = 1'b1; addr2 = 4'hC; d2writeback = 16'h2BC3;
    step();
    expect_rd("rd_dual_write", 4'hA, 4'hC, 16'h1A1A, 16'h2BC3, 2'b11, 5'd0);
    step();

    reserve(4'd5, 1'b1, "rsv5_first");
    step();
    reserve(4'd5, 1'b0, "rsv5_again");
    expect_rd("rd_busy5", 4'd5, 4'd5, 16'h0000, 16'h0000, 2'b00, 5'd1);
    step();

    // The write releases 5 while port 0 reads it.
    w_enable1 = 1'b1; addr1 = 4'd5; d1writeback = 16'hBEEF;
    expect_rd("rd_release5", 4'd5, 4'hA, BYP ? 16'hBEEF : 16'h0000, 16'h1A1A,
              {1'b1, BYP}, 5'd0);
    step();
    expect_rd("rd_after5", 4'd5, 4'hC, 16'hBEEF, 16'h2BC3, 2'b11, 5'd0);
    step();

    reserve(4'd7, 1'b1, "rsv7_first");
    step();
    // Colliding writes to 7 plus a re-reservation of the busy register.
    w_enable1 = 1'b1; addr1 = 4'd7; d1writeback = 16'h1111;
    w_enable2 = 1'b1; addr2 = 4'd7; d2writeback = 16'h2222;
    reserve(4'd7, 1'b1, "rsv7_on_release");
    expect_rd("rd_collide7", 4'd7, 4'd3, BYP ? 16'h2222 : 16'h0000, 16'h0000,
              2'b10, 5'd1);
    step();
    expect_rd("rd_after7", 4'd7, 4'd7, 16'h2222, 16'h2222, 2'b00, 5'd1);
    step();

    w_enable2 = 1'b1; addr2 = 4'd7; d2writeback = 16'h0007;
    step();
    w_enable1 = 1'b1; addr1 = 4'd9; d1writeback = 16'hABCD;
    expect_rd("rd_bypass9", 4'd9, 4'd7, BYP ? 16'hABCD : 16'h0000, 16'h0007,
              2'b11, 5'd0);
    step();

    for (int i = 1; i <= 4; i++) begin
      reserve(4'(i), 1'b1, "rsv_four");
      step();
    end
    expect_rd("rd_before_rst", 4'd8, 4'd9, 16'h0000, 16'hABCD, 2'b11, 5'd4);
    step();

    // Asynchronous reset between clock edges.
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(busy_cnt), 0);
    chk("async_rst_rdy", 32'(rd_ready), 0);
    chk("async_rst_data", rd_data, 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    reserve(4'd1, 1'b1, "rsv1_after_rst");
    step();
    expect_rd("rd_after_rst", 4'd1, 4'd9, 16'h0000, 16'h0000, 2'b10, 5'd1);
    step();

    for (int i = 0; i < 16; i++) begin
      reserve(4'(i), (i != 1), "rsv_fill");
      step();
    end
    expect_rd("rd_full", 4'd0, 4'd15, 16'h0000, 16'h0000, 2'b00, 5'd16);
    step();
    reserve(4'd0, 1'b0, "rsv_when_full");
    step();

    // Release and reserve the same register while every entry is busy.
    w_enable1 = 1'b1; addr1 = 4'd3; d1writeback = 16'h0033;
    reserve(4'd3, 1'b1, "rsv3_full_release");
    expect_rd("rd_full_swap", 4'd3, 4'd3, BYP ? 16'h0033 : 16'h0000,
              BYP ? 16'h0033 : 16'h0000, 2'b00, 5'd16);
    step();
    expect_rd("rd_after_swap", 4'd3, 4'd4, 16'h0033, 16'h0000, 2'b00, 5'd16);
    step();

    step();
    step();
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 2W/16x16 register file.
- Multi-read-port, dual-write-port register file with a per-register busy scoreboard, so decode can stall on registers with a pending writeback.
- Registered read data and a per-port ready flag.
- Sits between decode/issue, which reserves destinations, and writeback, which writes and releases them.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
RD_PORTS, 2, number of read ports (1..4)

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
rd_addr  in  RD_PORTS*ADDR_W  read addresses; port p occupies [p*ADDR_W +: ADDR_W]
rd_data  out  RD_PORTS*DATA_W  registered read data; port p at [p*DATA_W +: DATA_W]
rd_ready  out  RD_PORTS  registered: 1 = register was not busy, so the data is final
w_enable1  in  1  write port 1 enable
addr1  in  ADDR_W  write port 1 address
d1writeback  in  DATA_W  write port 1 data
w_enable2  in  1  write port 2 enable
addr2  in  ADDR_W  write port 2 address
d2writeback  in  DATA_W  write port 2 data
rsv_en  in  1  reserve request: mark rsv_addr busy
rsv_addr  in  ADDR_W  register to reserve
rsv_ok  out  1  combinational grant for the current rsv request
busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, rd_data = 0, rd_ready = 0, busy_cnt = 0.
- Reset mid-operation discards every pending reservation immediately.
- Write, on posedge: if w_enableN, regs[addrN] <= dNwriteback and busy[addrN] <= 0 (release).
- Write collision (both enables, addr1 == addr2): port 2 data wins; busy bit cleared once.
- Reserve grant: rsv_ok = rsv_en & (~busy[rsv_addr] | released_this_cycle(rsv_addr)).
  - released_this_cycle = a write to that address on either port in the same cycle.
- Reserve, on posedge: if rsv_ok, busy[rsv_addr] <= 1.
- Reserve vs. release on the same address and cycle: the write happens, the register ends busy (new owner), rsv_ok = 1.
- Refused reserve (rsv_en=1, rsv_ok=0): no state change; the requester retries.
- busy_cnt = number of set busy bits after the edge, updated with them. Range 0..DEPTH, never wraps.
- Read latency is 1 cycle. On posedge, for each port p:
  - rd_data[p] <= regs[rd_addr[p]] (pre-write value, unless bypass enabled);
  - rd_ready[p] <= ~busy[rd_addr[p]] (pre-edge busy, unless bypass enabled).
- Read ports are independent; any number may read the same address.
- No priority between reads and writes other than what is stated above.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding. If a read address matches a same-cycle write (port 2 preferred on collision), then:
  - rd_data gets the write data;
  - rd_ready = 1, unless the same address is also granted a reservation that cycle, in which case rd_ready = 0.
- Undefined: reads return the stored pre-write value with pre-edge busy status. Forwarding logic is absent.

Test Plan:
- Reset, then read addr 3 and 12 → after 1 clk rd_data = 0000/0000, rd_ready = 11, busy_cnt = 0.
- w_enable1=1, addr1=A, d1wb=1A1A; w_enable2=1, addr2=C, d2wb=2BC3; next cycle read A,C → rd_data = 1A1A/2BC3, rd_ready = 11.
- Reserve 5 (rsv_ok=1), then reserve 5 again → rsv_ok=0, busy_cnt stays 1. Read 5 → rd_ready=0. Write 5=BEEF → busy_cnt=0, next read 5 → BEEF, ready 1.
- Both writes to addr 7 (1111 on port 1, 2222 on port 2) → register 7 = 2222. Same cycle, reserve 7 while busy → rsv_ok=1, busy_cnt=1 afterwards.
- Bypass (RF_BYPASS_EN): write 9=ABCD while port 0 reads 9 → rd_data = ABCD next cycle. Without the macro → previous value 0000.
- Reserve 4 registers, assert rst mid-cycle (async) → busy_cnt=0 and rd_ready=0 immediately, without waiting for a clock edge.
